// File: rtl/capture_pkg.sv
// Shared encodings and default constants for the single-frame capture sequencer.
package capture_pkg;

   // Sequencer states; the numeric values are visible on oState for debug.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARM     = 3'd1,
      S_CAPTURE = 3'd2,
      S_STOPACK = 3'd3,
      S_HOLD    = 3'd4,
      S_RESUME  = 3'd5,
      S_ERR     = 3'd6,
      S_LOCKED  = 3'd7
   } state_t;

   // Error codes reported on oErrCode.
   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_FRAME   = 2'b10;
   localparam logic [1:0] ERR_ACK     = 2'b11;

   // Default frame geometry and timing limits.
   localparam int DEF_EXP_LINES = 960;
   localparam int DEF_TIMEOUT   = 10_000_000;
   localparam int DEF_ACK_CYC   = 4;

endpackage

// File: rtl/capture_sequencer_sync_edge_det.sv
// Registers a signal that is already synchronous to clk and reports its
// rising and falling edges from the registered copy (one cycle of latency).
module sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic sig_q, sig_d;
   logic prev_q, prev_d;

   // Next values: sample the input, and keep one cycle of history of the sample.
   always_comb begin
      sig_d  = d;
      prev_d = sig_q;
   end

   // Sample register and its one-cycle history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q  <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         sig_q  <= sig_d;
         prev_q <= prev_d;
      end
   end

   assign rise = sig_q & ~prev_q;
   assign fall = ~sig_q & prev_q;

endmodule

// File: rtl/capture_sequencer.sv
// Sequences a single camera-frame capture around stop_handler: waits for a
// clean frame start, lets one whole frame reach the buffer, freezes it until
// the processor releases it, and escalates timeouts, handshake failures and
// the permanent-lockout interrupt.
module capture_sequencer
   import capture_pkg::*;
#(
   parameter int LINE_W    = 12,
   parameter int EXP_LINES = DEF_EXP_LINES,
   parameter int TO_W      = 24,
   parameter int TIMEOUT   = DEF_TIMEOUT,
   parameter int ACK_CYC   = DEF_ACK_CYC
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iCapReq,
   input  logic              iRelease,
   input  logic              iInterrupt,
   input  logic              iFVAL,
   input  logic              iLVAL,
   input  logic              iStopped,
   output logic              oStop,
   output logic              oGo,
   output logic              oInterrupt,
   output logic              oBusy,
   output logic              oFrameDone,
   output logic              oError,
   output logic [1:0]        oErrCode,
   output logic [LINE_W-1:0] oLineCount,
   output logic [2:0]        oState
);

   localparam int                ACK_W    = (ACK_CYC > 1) ? $clog2(ACK_CYC) : 1;
   localparam logic [TO_W-1:0]   WD_LAST  = TO_W'(TIMEOUT - 1);
   localparam logic [ACK_W-1:0]  ACK_LAST = ACK_W'(ACK_CYC - 1);
   localparam logic [LINE_W-1:0] EXP_CNT  = LINE_W'(EXP_LINES);

   // Line counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [LINE_W-1:0] sat_inc(input logic [LINE_W-1:0] v);
      return (v == '1) ? v : v + LINE_W'(1);
   endfunction

   state_t              state_q, state_d;
   logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
   logic [TO_W-1:0]     wd_q, wd_d;
   logic [ACK_W-1:0]    ack_q, ack_d;
   logic                err_q, err_d;
   logic [1:0]          code_q, code_d;
   logic                stop_q, stop_d;
   logic                go_q, go_d;
   logic                int_q, int_d;

   logic fval_rise, fval_fall;
   logic lval_fall;
   logic lval_rise_unused;
   logic wd_live;

   sync_edge_det u_fval_edge (
      .clk   (iCLK),
      .rst_n (iRST),
      .d     (iFVAL),
      .rise  (fval_rise),
      .fall  (fval_fall)
   );

   sync_edge_det u_lval_edge (
      .clk   (iCLK),
      .rst_n (iRST),
      .d     (iLVAL),
      .rise  (lval_rise_unused),
      .fall  (lval_fall)
   );

   assign wd_live = (state_q == S_ARM) || (state_q == S_CAPTURE);

   // Next-state, counter and pulse decisions; interrupt outranks the
   // watchdog, which outranks the normal per-state behaviour.
   always_comb begin
      state_d    = state_q;
      line_cnt_d = line_cnt_q;
      wd_d       = wd_q;
      ack_d      = ack_q;
      err_d      = err_q;
      code_d     = code_q;
      stop_d     = 1'b0;
      go_d       = 1'b0;
      int_d      = iInterrupt;

      if (iInterrupt && (state_q != S_LOCKED)) begin
         // A stop already on the wire this cycle counts as the entry pulse.
         state_d = S_LOCKED;
         stop_d  = ~iStopped & ~stop_q;
      end else if (wd_live && (wd_q == WD_LAST)) begin
         state_d = S_ERR;
         stop_d  = 1'b1;
         err_d   = 1'b1;
         code_d  = ERR_TIMEOUT;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (iCapReq) begin
                  state_d = S_ARM;
                  wd_d    = '0;
                  go_d    = iStopped;
               end
            end
            S_ARM: begin
               wd_d = wd_q + TO_W'(1);
               if (fval_rise) begin
                  line_cnt_d = '0;
                  state_d    = S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               wd_d = wd_q + TO_W'(1);
               // Counted first so a line ending with the frame is included.
               if (lval_fall) begin
                  line_cnt_d = sat_inc(line_cnt_q);
               end
               if (fval_fall) begin
                  stop_d  = 1'b1;
                  ack_d   = '0;
                  state_d = S_STOPACK;
               end
            end
            S_STOPACK: begin
               if (iStopped) begin
                  state_d = S_HOLD;
                  if (line_cnt_q != EXP_CNT) begin
                     err_d  = 1'b1;
                     code_d = ERR_FRAME;
                  end
               end else if (ack_q == ACK_LAST) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
                  code_d  = ERR_ACK;
               end else begin
                  ack_d = ack_q + ACK_W'(1);
               end
            end
            S_HOLD, S_ERR: begin
               if (iRelease) begin
                  go_d    = 1'b1;
                  err_d   = 1'b0;
                  code_d  = ERR_NONE;
                  ack_d   = '0;
                  state_d = S_RESUME;
               end
            end
            S_RESUME: begin
               if (!iStopped) begin
                  state_d = S_IDLE;
               end else if (ack_q == ACK_LAST) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
                  code_d  = ERR_ACK;
               end else begin
                  ack_d = ack_q + ACK_W'(1);
               end
            end
            S_LOCKED: begin
               state_d = S_LOCKED;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State, counters, sticky error and registered pulse outputs.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q    <= S_IDLE;
         line_cnt_q <= '0;
         wd_q       <= '0;
         ack_q      <= '0;
         err_q      <= 1'b0;
         code_q     <= ERR_NONE;
         stop_q     <= 1'b0;
         go_q       <= 1'b0;
         int_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         line_cnt_q <= line_cnt_d;
         wd_q       <= wd_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         code_q     <= code_d;
         stop_q     <= stop_d;
         go_q       <= go_d;
         int_q      <= int_d;
      end
   end

   assign oStop      = stop_q;
   assign oGo        = go_q;
   assign oInterrupt = int_q;
   assign oBusy      = (state_q != S_IDLE);
   assign oFrameDone = (state_q == S_HOLD);
   assign oError     = err_q;
   assign oErrCode   = code_q;
   assign oLineCount = line_cnt_q;
   assign oState     = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: directed scenarios plus randomized frames,
// checked against expectations derived from frame content and handshake rules.
module tb_capture_sequencer;

   localparam int EXP   = 960;
   localparam int ACK   = 4;
   localparam int TO_T  = 100;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ARM  = 3'd1;
   localparam logic [2:0] ST_CAP  = 3'd2;
   localparam logic [2:0] ST_SACK = 3'd3;
   localparam logic [2:0] ST_HOLD = 3'd4;
   localparam logic [2:0] ST_RES  = 3'd5;
   localparam logic [2:0] ST_ERR  = 3'd6;
   localparam logic [2:0] ST_LOCK = 3'd7;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cap_req = 1'b0;
   logic rel = 1'b0;
   logic intr = 1'b0;
   logic fval = 1'b0;
   logic lval = 1'b0;
   logic sh_stuck = 1'b0;
   logic force_stop = 1'b0;

   logic sh_m_q, sh_t_q, stopped_m, stopped_t;

   logic        m_stop, m_go, m_int, m_busy, m_done, m_err;
   logic [1:0]  m_code;
   logic [11:0] m_lines;
   logic [2:0]  m_state;

   logic        t_stop, t_go, t_int, t_busy, t_done, t_err;
   logic [1:0]  t_code;
   logic [11:0] t_lines;
   logic [2:0]  t_state;

   int   total = 0;
   int   bad = 0;
   int   stop_cnt = 0;
   int   go_cnt = 0;
   logic prev_stop = 1'b0;
   logic prev_go = 1'b0;

   always #5 clk = ~clk;

   capture_sequencer dut (
      .iCLK(clk), .iRST(rst_n), .iCapReq(cap_req), .iRelease(rel),
      .iInterrupt(intr), .iFVAL(fval), .iLVAL(lval), .iStopped(stopped_m),
      .oStop(m_stop), .oGo(m_go), .oInterrupt(m_int), .oBusy(m_busy),
      .oFrameDone(m_done), .oError(m_err), .oErrCode(m_code),
      .oLineCount(m_lines), .oState(m_state)
   );

   capture_sequencer #(.TIMEOUT(TO_T)) dut_t (
      .iCLK(clk), .iRST(rst_n), .iCapReq(cap_req), .iRelease(rel),
      .iInterrupt(intr), .iFVAL(fval), .iLVAL(lval), .iStopped(stopped_t),
      .oStop(t_stop), .oGo(t_go), .oInterrupt(t_int), .oBusy(t_busy),
      .oFrameDone(t_done), .oError(t_err), .oErrCode(t_code),
      .oLineCount(t_lines), .oState(t_state)
   );

   // Simple stop_handler stand-ins: stopped follows stop/go one cycle later.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) sh_m_q <= 1'b0;
      else if (!sh_stuck) begin
         if (m_stop) sh_m_q <= 1'b1;
         else if (m_go) sh_m_q <= 1'b0;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) sh_t_q <= 1'b0;
      else if (t_stop) sh_t_q <= 1'b1;
      else if (t_go) sh_t_q <= 1'b0;
   end

   assign stopped_m = sh_m_q | force_stop;
   assign stopped_t = sh_t_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse rules: stop and go never together, each exactly one cycle wide.
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_stop || m_go) check("m_pulse_excl", 32'(m_stop & m_go), 0);
         if (m_stop) check("m_stop_width", 32'(prev_stop), 0);
         if (m_go) check("m_go_width", 32'(prev_go), 0);
         if (t_stop || t_go) check("t_pulse_excl", 32'(t_stop & t_go), 0);
         stop_cnt = stop_cnt + int'(m_stop);
         go_cnt = go_cnt + int'(m_go);
      end
      prev_stop = m_stop;
      prev_go = m_go;
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_state(input string tag, input logic [2:0] st, input int lim);
      int n = 0;
      while (m_state !== st && n < lim) begin
         tick();
         n++;
      end
      check(tag, 32'(m_state), 32'(st));
   endtask

   task automatic pulse_req();
      cap_req = 1'b1;
      tick();
      cap_req = 1'b0;
   endtask

   task automatic lines(input int n);
      for (int i = 0; i < n; i++) begin
         lval = 1'b1; tick();
         lval = 1'b0; tick();
      end
   endtask

   // One frame of n lines; returns on the cycle FVAL has just been driven low.
   task automatic send_frame(input int n, input bit simul, input bit rnd);
      fval = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      for (int i = 0; i < n; i++) begin
         lval = 1'b1;
         repeat (rnd ? $urandom_range(1, 3) : 1) tick();
         if (i == n - 1 && simul) begin
            lval = 1'b0;
            fval = 1'b0;
         end else begin
            lval = 1'b0;
            repeat (rnd ? $urandom_range(1, 3) : 1) tick();
         end
      end
      if (!simul) begin
         repeat ($urandom_range(1, 3)) tick();
         fval = 1'b0;
      end
   endtask

   // Stop timing, then HOLD contents predicted from the number of lines sent.
   task automatic finish_frame(input string tag, input int exp_n);
      logic       exp_err;
      logic [1:0] exp_code;
      exp_err  = (exp_n != EXP);
      exp_code = (exp_n != EXP) ? 2'b10 : 2'b00;
      tick();
      check({tag, "_stop_early"}, 32'(m_stop), 0);
      tick();
      check({tag, "_stop_pulse"}, 32'(m_stop), 1);
      check({tag, "_lines_at_stop"}, 32'(m_lines), exp_n);
      wait_state({tag, "_hold"}, ST_HOLD, 8);
      check({tag, "_done"}, 32'(m_done), 1);
      check({tag, "_busy"}, 32'(m_busy), 1);
      check({tag, "_lines"}, 32'(m_lines), exp_n);
      check({tag, "_err"}, 32'(m_err), 32'(exp_err));
      check({tag, "_code"}, 32'(m_code), 32'(exp_code));
   endtask

   task automatic release_frame(input string tag);
      rel = 1'b1;
      tick();
      rel = 1'b0;
      check({tag, "_go"}, 32'(m_go), 1);
      check({tag, "_resume"}, 32'(m_state), 32'(ST_RES));
      wait_state({tag, "_idle"}, ST_IDLE, ACK + 1);
      check({tag, "_err_clr"}, 32'(m_err), 0);
      check({tag, "_code_clr"}, 32'(m_code), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_stop"}, 32'(m_stop), 0);
      check({tag, "_go"}, 32'(m_go), 0);
      check({tag, "_int"}, 32'(m_int), 0);
      check({tag, "_busy"}, 32'(m_busy), 0);
      check({tag, "_done"}, 32'(m_done), 0);
      check({tag, "_err"}, 32'(m_err), 0);
      check({tag, "_code"}, 32'(m_code), 0);
      check({tag, "_lines"}, 32'(m_lines), 0);
      check({tag, "_state"}, 32'(m_state), 32'(ST_IDLE));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time bound exceeded");
   end

   initial begin
      int s0, g0, n;
      bit simul;

      // Reset values
      repeat (3) tick();
      check_reset_outputs("reset");
      check("reset_t_state", 32'(t_state), 32'(ST_IDLE));
      rst_n = 1'b1;
      tick();

      // Nominal: request mid-frame, that partial frame must be skipped
      fval = 1'b1;
      tick(); tick();
      lines(10);
      pulse_req();
      check("nom_arm", 32'(m_state), 32'(ST_ARM));
      lines(10);
      fval = 1'b0;
      repeat (3) tick();
      check("nom_partial_skipped", 32'(m_state), 32'(ST_ARM));
      send_frame(EXP, 1'b0, 1'b0);
      finish_frame("nom", EXP);
      release_frame("nom");

      // Short frame, with request taken while stop_handler still reports stopped
      force_stop = 1'b1;
      tick();
      pulse_req();
      check("short_req_go", 32'(m_go), 1);
      check("short_req_arm", 32'(m_state), 32'(ST_ARM));
      force_stop = 1'b0;
      send_frame(950, 1'b0, 1'b0);
      finish_frame("short", 950);
      release_frame("short");

      // Last line ends together with the frame
      pulse_req();
      send_frame(EXP, 1'b1, 1'b0);
      finish_frame("simul", EXP);
      release_frame("simul");

      // Randomized frames
      for (int k = 0; k < 3; k++) begin
         n = int'($urandom_range(955, 965));
         simul = 1'($urandom_range(0, 1));
         pulse_req();
         send_frame(n, simul, 1'b1);
         finish_frame("rnd", n);
         release_frame("rnd");
      end

      // Stop never acknowledged
      sh_stuck = 1'b1;
      pulse_req();
      send_frame(8, 1'b0, 1'b0);
      tick();
      check("ack_stop_early", 32'(m_stop), 0);
      tick();
      check("ack_stop_pulse", 32'(m_stop), 1);
      check("ack_stopack", 32'(m_state), 32'(ST_SACK));
      repeat (ACK - 1) tick();
      check("ack_still_waiting", 32'(m_state), 32'(ST_SACK));
      tick();
      check("ack_err_state", 32'(m_state), 32'(ST_ERR));
      check("ack_err", 32'(m_err), 1);
      check("ack_code", 32'(m_code), 32'(2'b11));
      sh_stuck = 1'b0;
      release_frame("ack");

      // Watchdog on the short-timeout instance, FVAL held low
      do_reset();
      fval = 1'b0;
      pulse_req();
      check("to_arm", 32'(t_state), 32'(ST_ARM));
      repeat (TO_T - 1) tick();
      check("to_stop_early", 32'(t_stop), 0);
      tick();
      check("to_stop_pulse", 32'(t_stop), 1);
      check("to_state", 32'(t_state), 32'(ST_ERR));
      check("to_code", 32'(t_code), 32'(2'b01));
      check("to_err", 32'(t_err), 1);
      rel = 1'b1;
      tick();
      rel = 1'b0;
      check("to_go", 32'(t_go), 1);
      check("to_resume", 32'(t_state), 32'(ST_RES));
      check("rel_ignored_go", 32'(m_go), 0);
      check("rel_ignored_state", 32'(m_state), 32'(ST_ARM));

      // Interrupt during capture
      do_reset();
      pulse_req();
      fval = 1'b1;
      tick(); tick();
      lines(5);
      check("int_capture", 32'(m_state), 32'(ST_CAP));
      s0 = stop_cnt;
      g0 = go_cnt;
      intr = 1'b1;
      tick();
      intr = 1'b0;
      check("int_locked", 32'(m_state), 32'(ST_LOCK));
      check("int_stop", 32'(m_stop), 1);
      check("int_fwd", 32'(m_int), 1);
      lines(5);
      fval = 1'b0;
      repeat (3) tick();
      pulse_req();
      tick();
      rel = 1'b1;
      tick();
      rel = 1'b0;
      repeat (3) tick();
      check("int_still_locked", 32'(m_state), 32'(ST_LOCK));
      check("int_one_stop", 32'(stop_cnt - s0), 1);
      check("int_no_go", 32'(go_cnt - g0), 0);
      check("int_fwd_follows", 32'(m_int), 0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("int_reset");
      tick();
      rst_n = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Sequences single-frame capture around stop_handler; drives its iStop/iGo inputs.
- Lets exactly one complete camera frame be written to the frame buffer, then freezes the buffer until the processor releases it.
- Sits between the camera timing signals (FVAL/LVAL), the processor request/release handshake, and stop_handler.
- Also forwards the permanent-lockout interrupt.

Parameters:
- LINE_W, 12: width of the line counter.
- EXP_LINES, 960: expected lines per frame; used for the short-frame check.
- TO_W, 24: width of the watchdog counter.
- TIMEOUT, 10_000_000: cycles allowed in ARM or CAPTURE before a timeout error.
- ACK_CYC, 4: cycles allowed for the stop_handler state to follow a pulse.

Ports:
- iCLK  in  1  system clock
- iRST  in  1  async active-low reset
- iCapReq  in  1  capture request pulse from processor
- iRelease  in  1  processor done with frame; resume live writes
- iInterrupt  in  1  permanent shutdown request
- iFVAL  in  1  camera frame valid (synchronous to iCLK)
- iLVAL  in  1  camera line valid (synchronous to iCLK)
- iStopped  in  1  oStop fed back from stop_handler
- oStop  out  1  1-cycle pulse to stop_handler iStop
- oGo  out  1  1-cycle pulse to stop_handler iGo
- oInterrupt  out  1  registered copy of iInterrupt to stop_handler
- oBusy  out  1  high in any state except IDLE
- oFrameDone  out  1  high in HOLD
- oError  out  1  sticky error; cleared on leaving HOLD/ERR via iRelease
- oErrCode  out  2  00 none, 01 timeout, 10 short/long frame, 11 ack failure
- oLineCount  out  LINE_W  lines counted in the last/current capture
- oState  out  3  current state encoding (debug)

Behaviour:
- Clock, reset: one clock iCLK. Reset is iRST, asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; counters 0.
- Edge detection: iFVAL and iLVAL are registered once. Edges are detected from the registered copy, so there is 1 cycle of detection latency.
- States:
  - IDLE=0, ARM=1, CAPTURE=2, STOPACK=3, HOLD=4, RESUME=5, ERR=6, LOCKED=7.
- IDLE:
  - iCapReq -> ARM; watchdog cleared.
  - iCapReq seen while iStopped=1: pulse oGo first, same transition.
- ARM:
  - Waits for an FVAL rising edge, so a partial frame is never used.
  - On the edge: line count cleared -> CAPTURE.
- CAPTURE:
  - Each LVAL falling edge increments the line count; it saturates at all-ones.
  - On an FVAL falling edge: pulse oStop -> STOPACK.
  - If an LVAL fall and an FVAL fall arrive in the same cycle, the line is counted before the stop is issued.
- STOPACK:
  - iStopped=1 within ACK_CYC cycles -> HOLD.
  - Otherwise -> ERR with code 11.
- HOLD:
  - oFrameDone=1.
  - On entry, if the line count != EXP_LINES, set oError with code 10. The frame is still presented.
  - iRelease -> pulse oGo -> RESUME.
- RESUME:
  - iStopped=0 within ACK_CYC cycles -> IDLE.
  - Otherwise -> ERR with code 11.
- Watchdog:
  - Counts in ARM and CAPTURE.
  - Reaching TIMEOUT -> pulse oStop, code 01 -> ERR.
- ERR:
  - oError=1; the buffer is held stopped.
  - iRelease -> pulse oGo, clear the error -> RESUME.
- LOCKED:
  - Any iInterrupt in any state -> LOCKED, with highest priority.
  - oInterrupt is a registered copy of iInterrupt (1 cycle), so stop_handler latches its permanent stop.
  - oStop is pulsed once on entry if iStopped=0.
  - Only reset exits LOCKED; all other inputs are ignored.
- Ignored inputs:
  - iCapReq outside IDLE.
  - iRelease outside HOLD/ERR.
- Pulses: oStop and oGo are never high in the same cycle, and each lasts exactly 1 cycle.
- Reset mid-capture: everything returns to reset values immediately, with no pulses issued.

Decomposition:
- Shared package capture_pkg holds:
  - state encodings (3-bit)
  - error codes (2-bit)
  - default EXP_LINES/TIMEOUT constants
- One sub-module, sync_edge_det: single-register edge detector with rise/fall outputs, instanced for FVAL and LVAL.

Test Plan:
- Nominal capture:
  - Stimulus: iCapReq mid-frame, then a full 960-line frame.
  - Required: oStop pulses one cycle after the FVAL fall is registered; oFrameDone=1; oLineCount=960; oError=0.
  - Then iRelease -> oGo pulse -> IDLE within ACK_CYC cycles.
- Short frame:
  - Stimulus: 950-line frame.
  - Required: HOLD with oError=1, oErrCode=10, oLineCount=950.
- Timeout:
  - Stimulus: iFVAL held low after iCapReq, with TIMEOUT set to 100 in the bench.
  - Required: oStop pulse at cycle 100; state ERR; oErrCode=01.
  - Then iRelease -> oGo pulse.
- Ack failure:
  - Stimulus: iStopped held 0 after the oStop pulse.
  - Required: ERR with oErrCode=11 after ACK_CYC cycles.
- Interrupt:
  - Stimulus: iInterrupt during CAPTURE.
  - Required: LOCKED; one oStop pulse; later iCapReq/iRelease produce no oGo.
  - Then iRST low -> IDLE with all outputs 0.
- Simultaneous edges:
  - Stimulus: LVAL fall coincident with FVAL fall at line 960.
  - Required: oLineCount=960 and oStop pulse in the same transition.
